// File: rtl/reg_mux_pkg.sv
// Shared constants and helpers for the registered N-way word multiplexer.
package reg_mux_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Index width for n items; never below one bit so single-bit ports stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping at N-1.
module rr_arbiter
    import reg_mux_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        int unsigned cand;
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        cand         = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!any_grant && req[SEL_W'(cand)]) begin
                any_grant                   = 1'b1;
                grant_idx                   = SEL_W'(cand);
                grant_onehot[SEL_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_mux_arb.sv
// Registered N-way word multiplexer with valid/ready handshake and a one-entry output stage.
// Source chosen either by the sel port or by round-robin over valid channels.
module reg_mux_arb
    import reg_mux_pkg::*;
#(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned NUM_INPUTS = 4,
    parameter  int unsigned ARB_MODE   = ARB_FIXED,
    localparam int unsigned SEL_W      = clog2_min1(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    output logic [NUM_INPUTS-1:0]       in_ready,
    input  logic [SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_src,
    output logic                        out_valid,
    input  logic                        out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_INPUTS-1:0]   grant_onehot;
    logic [SEL_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    can_load;
    logic                    in_xfer;
    logic [WIDTH-1:0]        sel_word;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr_q;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(.N(NUM_INPUTS)) u_rr_arbiter (
                .req          (in_valid),
                .ptr          (rr_ptr_q),
                .grant_onehot (grant_onehot),
                .grant_idx    (grant_idx),
                .any_grant    (grant_any)
            );

            // Pointer advances past the winner only when a word is actually taken.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr_q <= '0;
                end else if (in_xfer) begin
                    rr_ptr_q <= (32'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + SEL_W'(1);
                end
            end
        end else begin : g_fixed
            assign grant_idx = sel;

            // Out-of-range selects only exist when NUM_INPUTS is not a power of two.
            if (NUM_INPUTS == (1 << SEL_W)) begin : g_full_range
                assign grant_any = 1'b1;
            end else begin : g_part_range
                assign grant_any = (32'(sel) < NUM_INPUTS);
            end

            always_comb begin
                grant_onehot = '0;
                if (grant_any) begin
                    grant_onehot[sel] = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake and next state; a draining register can accept a new word the same cycle.
    always_comb begin
        state_d  = state_q;
        can_load = (state_q == ST_EMPTY) || out_ready;
        in_ready = grant_any ? (grant_onehot & {NUM_INPUTS{can_load}}) : '0;
        in_xfer  = |(in_ready & in_valid);
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_FULL;
            ST_FULL:  if (!in_xfer && out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
        end else if (in_xfer) begin
            out_data <= sel_word;
            out_src  <= grant_idx;
        end
    end

    assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_reg_mux_arb.sv
// Scoreboard bench for reg_mux_arb: FIXED N=4, RR N=4 and FIXED N=3 instances side by side.
module tb_reg_mux_arb;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [127:0] in_data   [ND];
    logic [3:0]   in_valid  [ND];
    logic [1:0]   sel       [ND];
    logic         out_ready [ND];
    logic [3:0]   in_ready  [ND];
    logic [31:0]  out_data  [ND];
    logic [1:0]   out_src   [ND];
    logic         out_valid [ND];

    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic [31:0] od0, od1, od2;
    logic [1:0]  os0, os1, os2;
    logic        ov0, ov1, ov2;

    reg_mux_arb #(.WIDTH(32), .NUM_INPUTS(4), .ARB_MODE(0)) u_fix4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(rdy0),
        .sel(sel[0]), .out_data(od0), .out_src(os0), .out_valid(ov0), .out_ready(out_ready[0]));
    reg_mux_arb #(.WIDTH(32), .NUM_INPUTS(4), .ARB_MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(rdy1),
        .sel(sel[1]), .out_data(od1), .out_src(os1), .out_valid(ov1), .out_ready(out_ready[1]));
    reg_mux_arb #(.WIDTH(32), .NUM_INPUTS(3), .ARB_MODE(0)) u_fix3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2][95:0]), .in_valid(in_valid[2][2:0]), .in_ready(rdy2),
        .sel(sel[2]), .out_data(od2), .out_src(os2), .out_valid(ov2), .out_ready(out_ready[2]));

    assign in_ready[0] = rdy0;
    assign in_ready[1] = rdy1;
    assign in_ready[2] = {1'b0, rdy2};
    assign out_data[0] = od0;
    assign out_data[1] = od1;
    assign out_data[2] = od2;
    assign out_src[0]  = os0;
    assign out_src[1]  = os1;
    assign out_src[2]  = os2;
    assign out_valid[0] = ov0;
    assign out_valid[1] = ov1;
    assign out_valid[2] = ov2;

    // Reference model: output-register occupancy, RR pointer, expected words {src, data}.
    bit          full_m [ND];
    int          ptr_m  [ND];
    logic [39:0] sb     [ND][$];
    int          n_err = 0;
    int          n_chk = 0;

    function automatic int nin(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic int grant_of(input int d, input logic [3:0] v, input int s, input int p);
        int n = nin(d);
        if (d != 1) return (s < n) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            full_m[d] = 1'b0;
            ptr_m[d]  = 0;
            sb[d].delete();
        end
    endtask

    task automatic idle();
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 4'b0;
            sel[d]       = 2'd0;
            out_ready[d] = 1'b1;
            in_data[d]   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        idle();
    endtask

    // Check handshake against the model, then record what the coming edge will transfer.
    task automatic settle();
        #1;
        for (int d = 0; d < ND; d++) begin
            int         g;
            bit         can;
            logic [3:0] er;
            g   = grant_of(d, in_valid[d], int'(sel[d]), ptr_m[d]);
            can = !full_m[d] || out_ready[d];
            er  = (g >= 0 && can) ? 4'(1 << g) : 4'b0;
            check($sformatf("in_ready_dut%0d", d), 64'(in_ready[d]), 64'(er));
            check($sformatf("out_valid_dut%0d", d), 64'(out_valid[d]), 64'(full_m[d]));
            if (g >= 0 && can && in_valid[d][g]) begin
                sb[d].push_back({8'(g), in_data[d][g*32 +: 32]});
                ptr_m[d]  = (g + 1) % nin(d);
                full_m[d] = 1'b1;
            end else if (out_ready[d]) begin
                full_m[d] = 1'b0;
            end
        end
    endtask

    // Monitor: whenever a word is presented it must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                for (int d = 0; d < ND; d++) begin
                    if (out_valid[d]) begin
                        if (sb[d].size() == 0) begin
                            check($sformatf("spurious_word_dut%0d", d), 64'd0, 64'd1);
                        end else begin
                            logic [39:0] e;
                            e = sb[d][0];
                            check($sformatf("out_data_dut%0d", d), 64'(out_data[d]), 64'(e[31:0]));
                            check($sformatf("out_src_dut%0d", d), 64'(out_src[d]), 64'(e[33:32]));
                            if (out_ready[d]) void'(sb[d].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w1, w2;
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        reset_model();
        #2;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_valid_dut%0d", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("rst_data_dut%0d", d), 64'(out_data[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // RR fairness with all channels requesting
        for (int k = 0; k < 8; k++) begin
            begin_cycle();
            in_valid[1] = 4'hF;
            settle();
            if (k > 0) check("rr_fair_src", 64'(out_src[1]), 64'((k - 1) % 4));
        end
        begin_cycle();
        in_valid[1] = 4'b0001;
        settle();
        check("rr_fair_src_last", 64'(out_src[1]), 64'd3);
        // RR skip and wrap from pointer 1
        begin_cycle();
        in_valid[1] = 4'b1001;
        settle();
        check("rr_skip_ready", 64'(in_ready[1]), 64'b1000);
        begin_cycle();
        in_valid[1] = 4'b1001;
        settle();
        check("rr_wrap_ready", 64'(in_ready[1]), 64'b0001);
        check("rr_skip_src", 64'(out_src[1]), 64'd3);
        begin_cycle();
        settle();
        check("rr_wrap_src", 64'(out_src[1]), 64'd0);
        begin_cycle();
        settle();
        check("rr_drained", 64'(out_valid[1]), 64'd0);
        begin_cycle();
        in_valid[1] = 4'hF;
        settle();
        check("rr_ptr_hold", 64'(in_ready[1]), 64'b0010);

        // FIXED basic transfer
        begin_cycle();
        sel[0] = 2'd2;
        in_data[0][95:64] = 32'hDEADBEEF;
        in_valid[0] = 4'b0100;
        settle();
        check("fix_ready", 64'(in_ready[0]), 64'b0100);
        begin_cycle();
        settle();
        check("fix_data", 64'(out_data[0]), 64'hDEADBEEF);
        check("fix_src", 64'(out_src[0]), 64'd2);
        check("fix_valid", 64'(out_valid[0]), 64'd1);

        // Backpressure: hold for three cycles, then replace on the draining edge
        begin_cycle();
        sel[0] = 2'd1;
        in_valid[0] = 4'hF;
        w1 = in_data[0][63:32];
        settle();
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            sel[0] = 2'd1;
            in_valid[0] = 4'hF;
            out_ready[0] = 1'b0;
            settle();
            check("stall_ready", 64'(in_ready[0]), 64'd0);
            check("stall_data", 64'(out_data[0]), 64'(w1));
        end
        begin_cycle();
        sel[0] = 2'd3;
        in_valid[0] = 4'hF;
        w2 = in_data[0][127:96];
        settle();
        check("replace_ready", 64'(in_ready[0]), 64'b1000);
        begin_cycle();
        settle();
        check("replace_data", 64'(out_data[0]), 64'(w2));
        check("replace_src", 64'(out_src[0]), 64'd3);

        // N=3 FIXED with out-of-range select
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            sel[2] = 2'd3;
            in_valid[2] = 4'b0111;
            settle();
            check("n3_oor_ready", 64'(in_ready[2]), 64'd0);
            check("n3_oor_valid", 64'(out_valid[2]), 64'd0);
        end
        begin_cycle();
        sel[2] = 2'd0;
        in_valid[2] = 4'b0111;
        settle();
        check("n3_resume_ready", 64'(in_ready[2]), 64'b0001);
        begin_cycle();
        settle();
        check("n3_resume_valid", 64'(out_valid[2]), 64'd1);

        // Random traffic, with an asynchronous reset in the middle of a held word
        for (int r = 0; r < 400; r++) begin
            begin_cycle();
            for (int d = 0; d < ND; d++) begin
                in_valid[d]  = 4'($urandom);
                sel[d]       = 2'($urandom);
                out_ready[d] = ($urandom_range(0, 9) < 7);
            end
            settle();
            if (r == 200) begin
                begin_cycle();
                sel[0] = 2'd1;
                in_valid[0] = 4'hF;
                settle();
                begin_cycle();
                for (int d = 0; d < ND; d++) out_ready[d] = 1'b0;
                settle();
                check("pre_rst_valid", 64'(out_valid[0]), 64'd1);
                #1 rst_n = 1'b0;
                reset_model();
                #1;
                for (int d = 0; d < ND; d++) begin
                    check($sformatf("midrst_valid_dut%0d", d), 64'(out_valid[d]), 64'd0);
                    check($sformatf("midrst_data_dut%0d", d), 64'(out_data[d]), 64'd0);
                    check($sformatf("midrst_src_dut%0d", d), 64'(out_src[d]), 64'd0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                begin_cycle();
                in_valid[1] = 4'hF;
                settle();
                check("rr_after_reset", 64'(in_ready[1]), 64'b0001);
            end
        end

        repeat (3) begin
            begin_cycle();
            settle();
        end
        #5;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("lost_words_dut%0d", d), 64'(sb[d].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
